// File: rtl/noc_mapper_receiver_if.sv
// Receiver-side bundle: credit-based flit link in, valid/ready payload out to the mapper.
// master drives flits, credit enable and ready; slave is the receiver.
interface noc_mapper_receiver_if #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1
);
  logic [FLIT_DATA_WIDTH+DEST_BITS+VC_BITS+1:0] flit_in;
  logic                                         en_put_credit;
  logic [VC_BITS:0]                             put_credit;
  logic [FLIT_DATA_WIDTH-1:0]                   data_out;
  logic                                         data_tail;
  logic                                         data_first;
  logic                                         data_valid;
  logic                                         data_ready;
  logic [15:0]                                  pkt_count;
  logic                                         overflow_err;
  logic                                         misroute_err;

  modport master (
    output flit_in, en_put_credit, data_ready,
    input  put_credit, data_out, data_tail, data_first, data_valid,
           pkt_count, overflow_err, misroute_err
  );

  modport slave (
    input  flit_in, en_put_credit, data_ready,
    output put_credit, data_out, data_tail, data_first, data_valid,
           pkt_count, overflow_err, misroute_err
  );
endinterface

// File: rtl/noc_mapper_receiver.sv
// Ejection endpoint: buffers flits for one mapper port, returns credits per freed slot,
// and tracks packet framing from the tail bit of popped flits.
module noc_mapper_receiver #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int MY_PORT         = 0,
  parameter int BUF_DEPTH       = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  noc_mapper_receiver_if.slave  bus
);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = AW + 2;
  localparam int FW  = FLIT_DATA_WIDTH;
  localparam int TOP = FW + DEST_BITS + VC_BITS + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic                 w_flit_vld, w_flit_tail;
  logic [DEST_BITS-1:0] w_flit_dest;
  logic [FW-1:0]        w_flit_data;
  logic                 w_match, w_misroute, w_full, w_pop, w_push, w_sent;
  logic                 w_head_tail;
  logic [PW-1:0]        w_pend_nxt;

  logic [FW:0]          r_mem [BUF_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [PW-1:0]        r_pend;
  logic                 r_put_vld;
  logic [15:0]          r_pkt_count;
  logic                 r_ovf, r_mis;
  state_t               r_state, w_state_nxt;

  // The vc field sits between dest and data and is deliberately not decoded.
  assign w_flit_vld  = bus.flit_in[TOP];
  assign w_flit_tail = bus.flit_in[TOP-1];
  assign w_flit_dest = bus.flit_in[FW+VC_BITS +: DEST_BITS];
  assign w_flit_data = bus.flit_in[FW-1:0];

  assign w_match    = w_flit_vld && (w_flit_dest == DEST_BITS'(MY_PORT));
  assign w_misroute = w_flit_vld && (w_flit_dest != DEST_BITS'(MY_PORT));
  assign w_full     = (r_count == CW'(BUF_DEPTH));
  assign w_pop      = (r_count != '0) && bus.data_ready;
  // A same-cycle pop frees a slot first, so a full FIFO can still accept.
  assign w_push     = w_match && (!w_full || w_pop);
  assign w_head_tail = r_mem[r_rd_ptr][FW];

  assign w_sent     = bus.en_put_credit && (r_pend != '0);
  assign w_pend_nxt = r_pend + PW'(w_pop) + PW'(w_misroute) - PW'(w_sent);

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_flit_tail, w_flit_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pend      <= '0;
      r_put_vld   <= 1'b0;
      r_pkt_count <= '0;
      r_ovf       <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_pend    <= w_pend_nxt;
      r_put_vld <= w_sent;
      if (w_pop && w_head_tail) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_match && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_misroute) r_mis <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop) w_state_nxt = w_head_tail ? IDLE : IN_PKT;
  end

  assign bus.put_credit   = {r_put_vld, VC_BITS'(0)};
  assign bus.data_out     = r_mem[r_rd_ptr][FW-1:0];
  assign bus.data_tail    = w_head_tail;
  assign bus.data_valid   = (r_count != '0);
  assign bus.data_first   = (r_count != '0) && (r_state == IDLE);
  assign bus.pkt_count    = r_pkt_count;
  assign bus.overflow_err = r_ovf;
  assign bus.misroute_err = r_mis;
endmodule

// File: tb/tb_noc_mapper_receiver.sv
// Bench for noc_mapper_receiver: vector table for the basic packet, hand sequences for
// overflow/misroute/credit-hold/reset corners, and a queue scoreboard checked every cycle.
module tb_noc_mapper_receiver;
  localparam int FW = 32;
  localparam int DB = 2;
  localparam int VB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_mapper_receiver_if #(.FLIT_DATA_WIDTH(FW), .DEST_BITS(DB), .VC_BITS(VB)) bus();

  noc_mapper_receiver #(
    .FLIT_DATA_WIDTH(FW), .DEST_BITS(DB), .VC_BITS(VB), .MY_PORT(0), .BUF_DEPTH(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic [FW-1:0] data;
    logic          tail;
  } exp_t;

  typedef struct {
    logic          vld;
    logic          tail;
    logic [FW-1:0] data;
    logic          exp_dv;
    logic [FW-1:0] exp_data;
    logic          exp_first;
    logic          exp_cred;
    logic [15:0]   exp_pkt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  int   m_count, m_pend, m_pkt;
  logic m_inpkt, m_putv, m_ovf, m_mis;
  int   n_cred, n_dpop, cyc, first_cred, last_cred;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic vld, input logic tail, input logic [DB-1:0] dest,
                       input logic [FW-1:0] data);
    bus.flit_in = {vld, tail, dest, 1'b0, data};
  endtask

  task automatic model_clear();
    q.delete();
    m_count = 0; m_pend = 0; m_pkt = 0;
    m_inpkt = 1'b0; m_putv = 1'b0; m_ovf = 1'b0; m_mis = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Called at the negedge: compare DUT against the model, then advance the model by one edge.
  task automatic model_step();
    logic vld, tail, pop, match, mis, sent;
    logic [DB-1:0] dest;
    exp_t e;
    vld  = bus.flit_in[FW+DB+VB+1];
    tail = bus.flit_in[FW+DB+VB];
    dest = bus.flit_in[FW+VB +: DB];
    chk("data_valid", 64'(bus.data_valid), 64'(m_count != 0));
    chk("data_first", 64'(bus.data_first), 64'((m_count != 0) && !m_inpkt));
    chk("put_credit", 64'(bus.put_credit), 64'({m_putv, 1'b0}));
    chk("pkt_count", 64'(bus.pkt_count), 64'(m_pkt[15:0]));
    chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
    chk("misroute_err", 64'(bus.misroute_err), 64'(m_mis));
    if (m_count != 0) begin
      chk("data_out", 64'(bus.data_out), 64'(q[0].data));
      chk("data_tail", 64'(bus.data_tail), 64'(q[0].tail));
    end
    if (bus.put_credit[VB]) begin
      n_cred++;
      if (first_cred < 0) first_cred = cyc;
      last_cred = cyc;
    end
    if (bus.data_valid && bus.data_ready) n_dpop++;
    pop   = (m_count != 0) && bus.data_ready;
    match = vld && (dest == '0);
    mis   = vld && (dest != '0);
    if (pop) begin
      e = q.pop_front();
      m_count--;
      if (e.tail) begin m_pkt++; m_inpkt = 1'b0; end
      else m_inpkt = 1'b1;
    end
    if (match) begin
      if (m_count < 8) begin
        e.data = bus.flit_in[FW-1:0];
        e.tail = tail;
        q.push_back(e);
        m_count++;
      end else m_ovf = 1'b1;
    end
    if (mis) m_mis = 1'b1;
    sent   = bus.en_put_credit && (m_pend != 0);
    m_putv = sent;
    m_pend = m_pend + int'(pop) + int'(mis) - int'(sent);
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
  endtask

  vec_t tv[7];
  int   c0, p0;

  initial begin
    tv[0] = '{1'b1, 1'b0, 32'hA1, 1'b0, 32'h0,  1'b0, 1'b0, 16'd0};
    tv[1] = '{1'b1, 1'b0, 32'hA2, 1'b1, 32'hA1, 1'b1, 1'b0, 16'd0};
    tv[2] = '{1'b1, 1'b1, 32'hA3, 1'b1, 32'hA2, 1'b0, 1'b0, 16'd0};
    tv[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hA3, 1'b0, 1'b1, 16'd0};
    tv[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 16'd1};
    tv[5] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 16'd1};
    tv[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 16'd1};

    n_cred = 0; n_dpop = 0; cyc = 0; first_cred = -1; last_cred = -1;
    bus.en_put_credit = 1'b1;
    bus.data_ready    = 1'b1;
    model_clear();
    do_reset();
    do_reset();
    tick();

    // Basic 3-flit packet from the vector table.
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].vld, tv[i].tail, 2'd0, tv[i].data);
      @(negedge clk);
      chk($sformatf("tv%0d_dv", i), 64'(bus.data_valid), 64'(tv[i].exp_dv));
      if (tv[i].exp_dv) chk($sformatf("tv%0d_data", i), 64'(bus.data_out), 64'(tv[i].exp_data));
      chk($sformatf("tv%0d_first", i), 64'(bus.data_first), 64'(tv[i].exp_first));
      chk($sformatf("tv%0d_cred", i), 64'(bus.put_credit[VB]), 64'(tv[i].exp_cred));
      chk($sformatf("tv%0d_pkt", i), 64'(bus.pkt_count), 64'(tv[i].exp_pkt));
      model_step();
      @(posedge clk); #1;
    end

    // Overflow: 9 pushes with the mapper stalled, then drain.
    bus.data_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, (i == 7), 2'd0, 32'h100 + i);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);
    chk("ovf_held", 64'(bus.data_valid), 64'd1);
    @(posedge clk); #1;
    bus.data_ready = 1'b1;
    c0 = n_cred; p0 = n_dpop;
    for (int i = 0; i < 14; i++) tick();
    chk("ovf_drain_pops", 64'(n_dpop - p0), 64'd8);
    chk("ovf_drain_creds", 64'(n_cred - c0), 64'd8);

    // Push and pop at full in the same cycle.
    do_reset();
    bus.data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 3) || (i == 7), 2'd0, 32'h300 + i);
      tick();
    end
    bus.data_ready = 1'b1;
    for (int i = 8; i < 12; i++) begin
      drive(1'b1, (i == 11), 2'd0, 32'h300 + i);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    bus.data_ready = 1'b0;
    tick();
    bus.data_ready = 1'b1;
    p0 = n_dpop;
    for (int i = 0; i < 14; i++) tick();
    chk("full_pp_no_ovf", 64'(bus.overflow_err), 64'd0);
    chk("full_pp_held8", 64'(n_dpop - p0), 64'd8);
    chk("full_pp_pkts", 64'(bus.pkt_count), 64'd3);

    // Misrouted flit returns its credit without being queued.
    do_reset();
    c0 = n_cred; p0 = n_dpop;
    drive(1'b1, 1'b1, 2'd2, 32'hBAD);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("mis_err", 64'(bus.misroute_err), 64'd1);
    chk("mis_creds", 64'(n_cred - c0), 64'd1);
    chk("mis_no_pop", 64'(n_dpop - p0), 64'd0);

    // Credits held back, then released as one contiguous burst.
    do_reset();
    bus.en_put_credit = 1'b0;
    bus.data_ready    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 4), 2'd0, 32'h500 + i);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    bus.data_ready = 1'b1;
    c0 = n_cred;
    for (int i = 0; i < 7; i++) tick();
    chk("hold_no_creds", 64'(n_cred - c0), 64'd0);
    first_cred = -1;
    bus.en_put_credit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_burst_creds", 64'(n_cred - c0), 64'd5);
    chk("hold_burst_span", 64'(last_cred - first_cred + 1), 64'd5);

    // Reset while mid-packet with 4 flits buffered and a credit pending.
    do_reset();
    bus.en_put_credit = 1'b0;
    bus.data_ready    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'd0, 32'h600 + i);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    @(negedge clk);
    chk("inpkt_first", 64'(bus.data_first), 64'd0);
    chk("inpkt_dv", 64'(bus.data_valid), 64'd1);
    @(posedge clk); #1;
    do_reset();
    bus.en_put_credit = 1'b1;
    @(negedge clk);
    chk("rst_dv", 64'(bus.data_valid), 64'd0);
    chk("rst_pkt", 64'(bus.pkt_count), 64'd0);
    @(posedge clk); #1;
    c0 = n_cred;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_no_creds", 64'(n_cred - c0), 64'd0);
    drive(1'b1, 1'b1, 2'd0, 32'h777);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_idle_first", 64'(bus.data_first), 64'd1);
    model_step();
    @(posedge clk); #1;
    bus.data_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0, $urandom);
      bus.data_ready    = ($urandom_range(0, 3) != 0);
      bus.en_put_credit = ($urandom_range(0, 2) != 0);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    bus.data_ready    = 1'b1;
    bus.en_put_credit = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
